bus_controller: RTL and testbench

BUS_CONTROLLER -- requirements
Module: bus_controller

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_wait_counter.sv | 26 ++
 rtl/bus_controller.sv | 144 ++++++++++++++
 tb/tb_bus_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - region/state enums, address map nibbles and region decode for bus_controller
package bus_pkg;

  typedef enum logic [2:0] {RAM, ROM, EXP, IO, NONE} region_e;
  typedef enum logic [2:0] {IDLE, WAIT, ACK, EXT, BERR} state_e;

  localparam logic [3:0] MAP_RAM = 4'h0;
  localparam logic [3:0] MAP_ROM = 4'hE;
  localparam logic [3:0] MAP_IO  = 4'hF;

  // Boot overlay only redirects reads of the lowest 256 KiB; writes always land in RAM.
  function automatic region_e decode_region(input logic [5:0] a, input logic rw,
                                            input logic cpusp_n, input logic boot);
    if (cpusp_n)
      return NONE;
    if (a[5:2] == MAP_RAM)
      return (boot && rw && a[1:0] == 2'b00) ? ROM : RAM;
    if (a[5:2] == MAP_ROM)
      return ROM;
    if (a[5:2] == MAP_IO)
      return IO;
    return EXP;
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// rtl/bus_wait_counter.sv - loadable down-counter for wait states, saturating at zero
module bus_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_controller.sv
// rtl/bus_controller.sv - 68k address decode, DTACK wait-state FSM and boot overlay
// Bus-error watchdog present only when BUS_CONTROLLER_BERR_EN is defined.
module bus_controller
  import bus_pkg::*;
#(
  parameter int RAM_WS      = 0,
  parameter int ROM_WS      = 1,
  parameter int EXP_WS      = 2,
  parameter int BOOT_CYCLES = 4,
  parameter int BERR_CYCLES = 64
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic [23:18] i_A,
  input  logic         i_AS_n,
  input  logic         i_UDS_n,
  input  logic         i_LDS_n,
  input  logic         i_RW,
  input  logic         i_CPUSP_n,
  input  logic         i_LGEXP_n,
  output logic         o_DTACK_n,
  output logic         o_BERR_n,
  output logic         o_WR,
  output logic         o_EVENRAM_n,
  output logic         o_ODDRAM_n,
  output logic         o_EVENROM_n,
  output logic         o_ODDROM_n,
  output logic         o_IOSEL_n,
  output logic         o_EXPSEL_n,
  output logic         o_BOOT
);

  localparam int WS_MAX = (RAM_WS > ROM_WS) ? ((RAM_WS > EXP_WS) ? RAM_WS : EXP_WS)
                                            : ((ROM_WS > EXP_WS) ? ROM_WS : EXP_WS);
  localparam int WS_W   = (WS_MAX < 1) ? 1 : $clog2(WS_MAX + 1);
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);

  state_e            state, state_next;
  region_e           region;
  logic              boot_r;
  logic [BOOT_W-1:0] boot_cnt;
  logic              ws_load, ws_dec, ws_zero;
  logic [WS_W-1:0]   ws_value;
  logic              as;
  logic              wd_expired;

  assign region = decode_region(i_A, i_RW, i_CPUSP_n, boot_r);
  assign as     = ~i_AS_n;

  assign o_WR        = ~i_RW;
  assign o_BOOT      = boot_r;
  assign o_EVENRAM_n = ~(as && region == RAM && !i_UDS_n);
  assign o_ODDRAM_n  = ~(as && region == RAM && !i_LDS_n);
  assign o_EVENROM_n = ~(as && region == ROM && !i_UDS_n);
  assign o_ODDROM_n  = ~(as && region == ROM && !i_LDS_n);
  assign o_IOSEL_n   = ~(as && region == IO);
  assign o_EXPSEL_n  = ~(as && region == EXP);

  assign o_DTACK_n = (state == ACK) ? 1'b0 : 1'bz;

`ifdef BUS_CONTROLLER_BERR_EN
  localparam int WD_W = (BERR_CYCLES < 2) ? 1 : $clog2(BERR_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(BERR_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Cleared whenever not waiting on an external acknowledge; holds at its limit.
  always_ff @(posedge i_CLK) begin
    if (i_RST || state != EXT)
      wd_cnt <= '0;
    else if (wd_cnt != WD_LAST)
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expired = (wd_cnt == WD_LAST);
  assign o_BERR_n   = (state == BERR) ? 1'b0 : 1'bz;
`else
  assign wd_expired = 1'b0;
  assign o_BERR_n   = 1'bz;
`endif

  bus_wait_counter #(.W(WS_W)) u_ws (
    .clk   (i_CLK),
    .rst   (i_RST),
    .load  (ws_load),
    .value (ws_value),
    .dec   (ws_dec),
    .zero  (ws_zero)
  );

  always_comb begin
    state_next = state;
    ws_load    = 1'b0;
    ws_dec     = 1'b0;
    ws_value   = '0;
    case (state)
      IDLE: begin
        if (as && !i_CPUSP_n) begin
          case (region)
            RAM: begin ws_load = 1'b1; ws_value = WS_W'(RAM_WS); state_next = WAIT; end
            ROM: begin ws_load = 1'b1; ws_value = WS_W'(ROM_WS); state_next = WAIT; end
            EXP: begin
              if (!i_LGEXP_n) begin
                ws_load = 1'b1; ws_value = WS_W'(EXP_WS); state_next = WAIT;
              end else begin
                state_next = EXT;
              end
            end
            default: state_next = EXT;
          endcase
        end
      end
      WAIT: begin
        if (i_AS_n)       state_next = IDLE;
        else if (ws_zero) state_next = ACK;
        else              ws_dec = 1'b1;
      end
      ACK:  if (i_AS_n) state_next = IDLE;
      EXT: begin
        if (i_AS_n)          state_next = IDLE;
        else if (wd_expired) state_next = BERR;
      end
      BERR: if (i_AS_n) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= IDLE;
      boot_r   <= 1'b1;
      boot_cnt <= '0;
    end else begin
      state <= state_next;
      if (boot_r && state != IDLE && state_next == IDLE) begin
        if (boot_cnt != BOOT_W'(BOOT_CYCLES))
          boot_cnt <= boot_cnt + 1'b1;
        if (boot_cnt + 1'b1 == BOOT_W'(BOOT_CYCLES))
          boot_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// tb/tb_bus_controller.sv - directed vector and sequence bench for bus_controller
module tb_bus_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] a = 6'h00;
  logic       as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic       cpusp_n = 1'b0, lgexp_n = 1'b1;
  wire        dtack_n, berr_n;
  logic       wr, evenram_n, oddram_n, evenrom_n, oddrom_n, iosel_n, expsel_n, boot;

  pullup (dtack_n);
  pullup (berr_n);

  bus_controller dut (
    .i_CLK(clk), .i_RST(rst), .i_A(a), .i_AS_n(as_n), .i_UDS_n(uds_n), .i_LDS_n(lds_n),
    .i_RW(rw), .i_CPUSP_n(cpusp_n), .i_LGEXP_n(lgexp_n), .o_DTACK_n(dtack_n),
    .o_BERR_n(berr_n), .o_WR(wr), .o_EVENRAM_n(evenram_n), .o_ODDRAM_n(oddram_n),
    .o_EVENROM_n(evenrom_n), .o_ODDROM_n(oddrom_n), .o_IOSEL_n(iosel_n),
    .o_EXPSEL_n(expsel_n), .o_BOOT(boot)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      name;
    logic [5:0] a;
    logic       rw, as_n, uds_n, lds_n, cpusp_n;
    logic [6:0] sel;  // {evenram, oddram, evenrom, oddrom, iosel, expsel, wr}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int dtack_on();
    return (dtack_n === 1'b0) ? 1 : 0;
  endfunction

  function automatic int berr_on();
    return (berr_n === 1'b0) ? 1 : 0;
  endfunction

  task automatic bus_cycle(input string name, input logic [5:0] addr, input logic r,
                           input logic lg, input int exp_lat);
    int lat;
    @(negedge clk);
    a = addr; rw = r; lgexp_n = lg; uds_n = 1'b0; lds_n = 1'b0; cpusp_n = 1'b0; as_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dtack_on() == 1) begin lat = i - 1; break; end
    end
    check({name, " dtack latency"}, lat, exp_lat);
  endtask

  task automatic end_cycle(input string name);
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; lgexp_n = 1'b1;
    @(posedge clk); #1;
    check({name, " dtack released"}, dtack_on(), 0);
  endtask

  initial begin
    int seen, first_berr, exp_berr;

    vecs[0] = '{"boot read 0",   6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100110};
    vecs[1] = '{"boot write 0",  6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0111111};
    vecs[2] = '{"read ram 1",    6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0011110};
    vecs[3] = '{"read io",       6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111010};
    vecs[4] = '{"read exp",      6'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111100};
    vecs[5] = '{"read rom odd",  6'h38, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1110110};
    vecs[6] = '{"cpu space",     6'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111110};
    vecs[7] = '{"as high",       6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111110};
    vecs[8] = '{"write io",      6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111011};
    vecs[9] = '{"write rom even",6'h38, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1101111};

    repeat (3) @(posedge clk);
    #1;
    check("reset dtack released", dtack_on(), 0);
    check("reset berr released", berr_on(), 0);
    check("reset boot", int'(boot), 1);
    @(negedge clk);
    rst = 1'b0;

    // Strobes are applied and removed inside one low clock phase so the FSM never sees AS low.
    foreach (vecs[k]) begin
      @(negedge clk);
      a = vecs[k].a; rw = vecs[k].rw; uds_n = vecs[k].uds_n; lds_n = vecs[k].lds_n;
      cpusp_n = vecs[k].cpusp_n; as_n = vecs[k].as_n;
      #1;
      check({"decode ", vecs[k].name},
            int'({evenram_n, oddram_n, evenrom_n, oddrom_n, iosel_n, expsel_n, wr}),
            int'(vecs[k].sel));
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; cpusp_n = 1'b0; rw = 1'b1;
    end

    bus_cycle("boot rom read", 6'h00, 1'b1, 1'b1, 2);
    check("boot rom lanes", int'({evenrom_n, oddrom_n, evenram_n}), 3'b001);
    check("boot active", int'(boot), 1);
    end_cycle("boot rom read");

    bus_cycle("ram read", 6'h01, 1'b1, 1'b1, 1);
    end_cycle("ram read");
    bus_cycle("ram write", 6'h01, 1'b0, 1'b1, 1);
    end_cycle("ram write");
    check("boot after 3 cycles", int'(boot), 1);

    @(negedge clk);
    a = 6'h3F; cpusp_n = 1'b1; as_n = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (dtack_on() == 1 || berr_on() == 1) seen = 1;
    end
    check("cpu space no strobes", seen, 0);
    @(negedge clk);
    as_n = 1'b1; cpusp_n = 1'b0;
    @(posedge clk); #1;
    check("cpu space not counted", int'(boot), 1);

    bus_cycle("rom read", 6'h38, 1'b1, 1'b1, 2);
    end_cycle("rom read");
    check("boot clears after 4", int'(boot), 0);

    bus_cycle("post-boot read 0", 6'h00, 1'b1, 1'b1, 1);
    check("post-boot ram lanes", int'({evenram_n, evenrom_n}), 2'b01);
    end_cycle("post-boot read 0");

    bus_cycle("exp internal", 6'h04, 1'b1, 1'b0, 3);
    end_cycle("exp internal");

    @(negedge clk);
    a = 6'h04; lgexp_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (dtack_on() == 1) seen = 1;
    end
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; lgexp_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (dtack_on() == 1) seen = 1;
    end
    check("exp abort no dtack", seen, 0);
    bus_cycle("ram after abort", 6'h01, 1'b1, 1'b1, 1);
    end_cycle("ram after abort");

`ifdef BUS_CONTROLLER_BERR_EN
    exp_berr = 64;
`else
    exp_berr = -1;
`endif
    @(negedge clk);
    a = 6'h3C; rw = 1'b1; lgexp_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    first_berr = -1;
    seen = 0;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      if (berr_on() == 1 && first_berr < 0) first_berr = i - 1;
      if (dtack_on() == 1) seen = 1;
    end
    check("io watchdog berr cycle", first_berr, exp_berr);
    check("io no dtack", seen, 0);
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(posedge clk); #1;
    check("io berr released", berr_on(), 0);

    bus_cycle("ram before reset", 6'h01, 1'b1, 1'b1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset in ack releases dtack", dtack_on(), 0);
    check("reset in ack rearms boot", int'(boot), 1);
    @(negedge clk);
    rst = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;

    bus_cycle("rearmed boot read", 6'h00, 1'b1, 1'b1, 2);
    check("rearmed rom lane", int'(evenrom_n), 0);
    end_cycle("rearmed boot read");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
